// File: rtl/scrambler_pkg.sv
// Keystream definitions shared by the scrambler and descrambler so the
// polynomial and the seed stay single-sourced.
package scrambler_pkg;

   localparam logic [7:0] LFSR_SEED = 8'hFF;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } lock_state_t;

   function automatic logic [7:0] lfsr_next(input logic [7:0] x);
      return {x[6:0], x[6] ^ x[3]};
   endfunction

   // A seed whose successor has zero low bits would stall the keystream.
   function automatic logic lfsr_degenerate(input logic [7:0] x);
      logic [7:0] n;
      n = lfsr_next(x);
      return (n[6:0] == 7'd0);
   endfunction

endpackage

// File: rtl/descrambler_lock_fsm.sv
// Keystream acquisition: seeds the LFSR from zero-plaintext training bytes
// and confirms alignment with consecutive predicted matches.
module descrambler_lock_fsm
   import scrambler_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int CNT_W      = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       resync_i,
   input  logic       accept_i,
   input  logic [7:0] data_i,
   output logic       locked_o,
   output logic       emit_o,
   output logic [7:0] lfsr_o
);

   localparam logic [CNT_W-1:0] LAST_MATCH = CNT_W'(LOCK_COUNT - 1);

   lock_state_t      state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       lfsr_q, lfsr_d;

   // Next-state logic; the keystream only advances on an accepted byte.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      lfsr_d  = lfsr_q;
      if (resync_i) begin
         state_d = HUNT;
         count_d = {CNT_W{1'b0}};
      end else if (accept_i) begin
         case (state_q)
            HUNT: begin
               if (!lfsr_degenerate(data_i)) begin
                  lfsr_d  = lfsr_next(data_i);
                  count_d = CNT_W'(1);
                  state_d = CHECK;
               end else begin
                  state_d = HUNT;
               end
            end
            CHECK: begin
               if (data_i == lfsr_q) begin
                  lfsr_d  = lfsr_next(lfsr_q);
                  count_d = count_q + CNT_W'(1);
                  if (count_q == LAST_MATCH) begin
                     state_d = LOCKED;
                  end else begin
                     state_d = CHECK;
                  end
               end else if (!lfsr_degenerate(data_i)) begin
                  lfsr_d  = lfsr_next(data_i);
                  count_d = CNT_W'(1);
                  state_d = CHECK;
               end else begin
                  count_d = {CNT_W{1'b0}};
                  state_d = HUNT;
               end
            end
            LOCKED: begin
               lfsr_d = lfsr_next(lfsr_q);
            end
            default: begin
               state_d = HUNT;
               count_d = {CNT_W{1'b0}};
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State, counter and keystream registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= HUNT;
         count_q <= {CNT_W{1'b0}};
         lfsr_q  <= LFSR_SEED;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         lfsr_q  <= lfsr_d;
      end
   end

   assign locked_o = (state_q == LOCKED);
   assign emit_o   = accept_i && !resync_i && (state_q == LOCKED);
   assign lfsr_o   = lfsr_q;

endmodule

// File: rtl/sync_descrambler.sv
// Receive-side byte descrambler: lock FSM plus a single-entry output register
// with ready/valid backpressure.
module sync_descrambler
   import scrambler_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int CNT_W      = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       resync,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic       locked,
   output logic [7:0] lfsr
);

   logic       accept_s;
   logic       emit_s;
   logic [7:0] lfsr_s;
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_data_q, out_data_d;

   assign in_ready = !out_valid_q || out_ready;
   assign accept_s = in_valid && in_ready;

   descrambler_lock_fsm #(
      .LOCK_COUNT (LOCK_COUNT),
      .CNT_W      (CNT_W)
   ) u_lock (
      .clk_i    (clock),
      .rst_n_i  (resetn),
      .resync_i (resync),
      .accept_i (accept_s),
      .data_i   (in_data),
      .locked_o (locked),
      .emit_o   (emit_s),
      .lfsr_o   (lfsr_s)
   );

   // Output register: a new payload byte wins over draining the current one.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (emit_s) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data ^ lfsr_s;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output holding register.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign lfsr      = lfsr_s;

endmodule

// File: tb/tb_sync_descrambler.sv
// Scoreboard bench for sync_descrambler: directed lock/backpressure/resync
// scenarios followed by randomized traffic against a training-run model.
module tb_sync_descrambler;

   localparam int LOCK_COUNT = 4;

   logic       clock = 1'b0;
   logic       resetn, resync, in_valid, out_ready;
   logic [7:0] in_data;
   logic       in_ready, out_valid, locked;
   logic [7:0] out_data, lfsr;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] sb_q[$];
   logic [7:0] run_q[$];
   logic [7:0] mon_exp;
   bit         m_ov     = 1'b0;
   bit         m_locked = 1'b0;
   logic [7:0] m_lfsr   = 8'hFF;
   logic [7:0] tx_ks;
   bit         acc;

   always #5 clock = ~clock;

   sync_descrambler #(.LOCK_COUNT(LOCK_COUNT), .CNT_W(4)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .resync    (resync),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .locked    (locked),
      .lfsr      (lfsr)
   );

   function automatic logic [7:0] tb_next(input logic [7:0] x);
      return {x[6:0], x[6] ^ x[3]};
   endfunction

   function automatic bit tb_degen(input logic [7:0] x);
      logic [7:0] n;
      n = tb_next(x);
      return (n[6:0] == 7'd0);
   endfunction

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // Training is a run of bytes, each the keystream successor of the previous;
   // LOCK_COUNT of them in a row means the keystream is known.
   task automatic model_byte(input logic [7:0] b);
      if (m_locked) begin
         sb_q.push_back(b ^ m_lfsr);
         m_lfsr = tb_next(m_lfsr);
      end else if (run_q.size() > 0 && b == tb_next(run_q[run_q.size()-1])) begin
         run_q.push_back(b);
         m_lfsr = tb_next(b);
         if (run_q.size() == LOCK_COUNT) begin
            m_locked = 1'b1;
            run_q.delete();
         end
      end else begin
         run_q.delete();
         if (!tb_degen(b)) begin
            run_q.push_back(b);
            m_lfsr = tb_next(b);
         end
      end
   endtask

   task automatic cycle(input logic v, input logic [7:0] d, input logic rs,
                        input logic ordy, input logic rn, output bit acc_o);
      bit emit;
      in_valid  = v;
      in_data   = d;
      resync    = rs;
      out_ready = ordy;
      resetn    = rn;
      #1;
      if (rn) check8("in_ready", {7'd0, in_ready}, {7'd0, (!m_ov || ordy)});
      acc_o = v && (!m_ov || ordy) && rn;
      emit  = acc_o && m_locked && !rs;
      @(posedge clock);
      #1;
      if (!rn) begin
         m_ov = 1'b0; m_locked = 1'b0; m_lfsr = 8'hFF;
         run_q.delete(); sb_q.delete();
      end else begin
         if (rs) begin
            m_locked = 1'b0;
            run_q.delete();
         end else if (acc_o) begin
            model_byte(d);
         end
         m_ov = emit ? 1'b1 : (ordy ? 1'b0 : m_ov);
      end
      check8("out_valid", {7'd0, out_valid}, {7'd0, m_ov});
      check8("locked", {7'd0, locked}, {7'd0, m_locked});
      check8("lfsr", lfsr, m_lfsr);
   endtask

   task automatic send(input logic [7:0] b);
      bit a;
      cycle(1'b1, b, 1'b0, 1'b1, 1'b1, a);
   endtask

   task automatic drain();
      bit a;
      for (int i = 0; i < 64 && sb_q.size() > 0; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, a);
      check8("drain_empty", 8'(sb_q.size()), 8'd0);
   endtask

   // Monitor: a transfer happens at the next rising edge whenever valid and
   // ready are both high at the falling edge.
   always @(negedge clock) begin
      if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL out_data: got unexpected byte %02h, expected none", out_data);
         end else begin
            mon_exp = sb_q.pop_front();
            check8("out_data", out_data, mon_exp);
         end
      end
   end

   initial begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
      check8("reset_lfsr", lfsr, 8'hFF);
      check8("reset_out_data", out_data, 8'h00);

      // zero preamble lock and first payload byte
      send(8'hFF); send(8'hFE); send(8'hFC);
      check8("pre_lock", {7'd0, locked}, 8'd0);
      send(8'hF8);
      check8("preamble_locked", {7'd0, locked}, 8'd1);
      check8("preamble_lfsr", lfsr, 8'hF0);
      send(8'h55);
      check8("payload_A5", out_data, 8'hA5);
      check8("payload_lfsr", lfsr, 8'hE1);
      drain();

      // mid-stream acquisition, then a corrupted run that must reseed
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, acc);
      send(8'hFC); send(8'hF8); send(8'hF0); send(8'hE1);
      check8("midstream_locked", {7'd0, locked}, 8'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, acc);
      send(8'hFC); send(8'hF8); send(8'h00); send(8'hF0);
      check8("corrupt_unlocked", {7'd0, locked}, 8'd0);
      send(8'hE1); send(8'hC3); send(8'h87);
      check8("corrupt_relocked", {7'd0, locked}, 8'd1);

      // degenerate seed keeps HUNT
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, acc);
      send(8'h80);
      check8("degen_unlocked", {7'd0, locked}, 8'd0);
      send(8'hFF); send(8'hFE); send(8'hFC); send(8'hF8);
      check8("degen_relock_lfsr", lfsr, 8'hF0);

      // backpressure: first byte parks, the rest are refused until release
      tx_ks = 8'hF0;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, tx_ks ^ 8'($urandom), 1'b0, 1'b0, 1'b1, acc);
         if (acc) tx_ks = tb_next(tx_ks);
         if (sb_q.size() > 0) check8("bp_hold", out_data, sb_q[0]);
      end
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, tx_ks ^ 8'($urandom), 1'b0, 1'b1, 1'b1, acc);
         if (acc) tx_ks = tb_next(tx_ks);
      end
      drain();

      // resync with a pending byte: refused input, then accepted-and-discarded input
      cycle(1'b1, tx_ks ^ 8'h3C, 1'b0, 1'b0, 1'b1, acc);
      if (acc) tx_ks = tb_next(tx_ks);
      cycle(1'b1, tx_ks ^ 8'h11, 1'b1, 1'b0, 1'b1, acc);
      check8("resync_drop", {7'd0, locked}, 8'd0);
      drain();
      send(8'hFF); send(8'hFE); send(8'hFC); send(8'hF8);
      tx_ks = 8'hF0;
      cycle(1'b1, tx_ks ^ 8'h5A, 1'b0, 1'b0, 1'b1, acc);
      if (acc) tx_ks = tb_next(tx_ks);
      cycle(1'b1, tx_ks ^ 8'h22, 1'b1, 1'b1, 1'b1, acc);
      check8("resync_coincident", {7'd0, locked}, 8'd0);
      drain();

      // reset while a byte is stalled in the output register
      send(8'hFF); send(8'hFE); send(8'hFC); send(8'hF8);
      cycle(1'b1, 8'hF0 ^ 8'hAA, 1'b0, 1'b0, 1'b1, acc);
      check8("pre_reset_valid", {7'd0, out_valid}, 8'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
      check8("midreset_valid", {7'd0, out_valid}, 8'd0);
      check8("midreset_lfsr", lfsr, 8'hFF);

      // randomized traffic: zero plaintext while unlocked, payload once locked
      tx_ks = 8'hFF;
      for (int i = 0; i < 2000; i++) begin
         logic [7:0] d;
         logic       rs;
         d  = ($urandom_range(0, 19) == 0) ? 8'($urandom)
              : (tx_ks ^ (m_locked ? 8'($urandom) : 8'h00));
         rs = ($urandom_range(0, 99) == 0);
         cycle(($urandom_range(0, 3) != 0), d, rs, ($urandom_range(0, 3) != 0), 1'b1, acc);
         if (acc) tx_ks = tb_next(tx_ks);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
